// File: rtl/ram4k_fifo_ctrl_if.sv
// Signal bundle between a 4096x8 FIFO controller and its user plus the external dual-port RAM.
// The slave modport is the controller; the master modport is its environment.
interface ram4k_fifo_ctrl_if;
  logic        clr;
  logic        wr;
  logic [7:0]  din;
  logic        rd;
  logic [7:0]  dout;
  logic        dv;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [12:0] count;
  logic        ovf;
  logic        unf;
  logic        ram_wce;
  logic        ram_we;
  logic [11:0] ram_wadr;
  logic [7:0]  ram_i;
  logic        ram_rce;
  logic [11:0] ram_radr;
  logic [7:0]  ram_o;

  modport master (
    output clr, wr, din, rd, ram_o,
    input  dout, dv, full, empty, almost_full, almost_empty, count, ovf, unf,
    input  ram_wce, ram_we, ram_wadr, ram_i, ram_rce, ram_radr
  );

  modport slave (
    input  clr, wr, din, rd, ram_o,
    output dout, dv, full, empty, almost_full, almost_empty, count, ovf, unf,
    output ram_wce, ram_we, ram_wadr, ram_i, ram_rce, ram_radr
  );
endinterface

// File: rtl/ram4k_fifo_ctrl.sv
// FIFO controller driving an external 4096x8 dual-port RAM (both ports on clk).
// Registered occupancy count, sticky over/underflow flags, one-cycle pop-to-data strobe.
module ram4k_fifo_ctrl #(
  parameter int unsigned AFULL  = 3840,
  parameter int unsigned AEMPTY = 256
) (
  input logic               clk,
  input logic               rst,
  ram4k_fifo_ctrl_if.slave  bus
);

  localparam logic [12:0] Depth   = 13'd4096;
  localparam logic [12:0] AfullC  = 13'(AFULL);
  localparam logic [12:0] AemptyC = 13'(AEMPTY);

  logic [11:0] wptr_q, wptr_d;
  logic [11:0] rptr_q, rptr_d;
  logic [12:0] count_q, count_d;
  logic        dv_q, dv_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic full, empty, wa, ra;

  // Flags come from the registered count only; no lookahead or bypass.
  assign full  = (count_q == Depth);
  assign empty = (count_q == 13'd0);

  // rst gating keeps the RAM strobes quiet while reset is held.
  assign wa = bus.wr & ~full  & ~bus.clr & ~rst;
  assign ra = bus.rd & ~empty & ~bus.clr & ~rst;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dv_d    = ra;
    ovf_d   = ovf_q | (bus.wr & full);
    unf_d   = unf_q | (bus.rd & empty);
    if (bus.clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      dv_d    = 1'b0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wa) wptr_d = wptr_q + 12'd1;
      if (ra) rptr_d = rptr_q + 12'd1;
      unique case ({wa, ra})
        2'b10:   count_d = count_q + 13'd1;
        2'b01:   count_d = count_q - 13'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.ram_wce      = wa;
  assign bus.ram_we       = wa;
  assign bus.ram_wadr     = wptr_q;
  assign bus.ram_i        = bus.din;
  assign bus.ram_rce      = ra;
  assign bus.ram_radr     = rptr_q;
  assign bus.dout         = bus.ram_o;
  assign bus.dv           = dv_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AfullC);
  assign bus.almost_empty = (count_q <= AemptyC);
  assign bus.count        = count_q;
  assign bus.ovf          = ovf_q;
  assign bus.unf          = unf_q;

endmodule

// File: doc/ram4k_fifo_ctrl.md
RAM4K_FIFO_CTRL -- requirements
Module: ram4k_fifo_ctrl

Interface
REQ-001 Parameter AFULL, default 3840: almost_full asserts when count >= AFULL.
REQ-002 Parameter AEMPTY, default 256: almost_empty asserts when count <= AEMPTY.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 clr  in  1  synchronous flush; empties the FIFO without touching RAM contents.
REQ-006 wr  in  1  push request.
REQ-007 din  in  8  push data.
REQ-008 rd  in  1  pop request.
REQ-009 dout  out  8  popped byte; equals ram_o while dv=1.
REQ-010 dv  out  1  one-cycle strobe: dout holds the byte popped in the previous cycle.
REQ-011 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-012 count  out  13  occupancy, 0..4096.
REQ-013 ovf, unf  out  1 each  sticky overflow/underflow flags.
REQ-014 ram_wce, ram_we  out  1 each  RAM write-port enable and write strobe.
REQ-015 ram_wadr  out  12  RAM write address.
REQ-016 ram_i  out  8  RAM write data.
REQ-017 ram_rce  out  1  RAM read-port enable.
REQ-018 ram_radr  out  12  RAM read address.
REQ-019 ram_o  in  8  RAM read data, registered-address, one-cycle latency.

Function
REQ-020 Storage is one 4096x8 dual-port RAM; the RAM's write and read clocks shall both connect to clk.
REQ-021 Push accepted (wa) = wr & ~full & ~clr; pop accepted (ra) = rd & ~empty & ~clr.
REQ-022 Combinational RAM drive: ram_wce = ram_we = wa; ram_wadr = wptr; ram_i = din.
REQ-023 Combinational RAM drive: ram_rce = ra; ram_radr = rptr.
REQ-024 On wa, wptr increments by 1 modulo 4096 (4095 -> 0); on ra, rptr increments likewise.
REQ-025 count: +1 on wa only, -1 on ra only, unchanged on both or neither; never leaves 0..4096.
REQ-026 full = (count == 4096); empty = (count == 0); both are decoded from registered count, no lookahead.
REQ-027 With full=1: wr is rejected even if ra occurs in the same cycle.
REQ-028 With empty=1: rd is rejected even if wa occurs in the same cycle; there is no write-through bypass.
REQ-029 dv is a register loaded with ra, so pop-to-data latency is exactly 1 cycle; back-to-back pops yield one byte per cycle.
REQ-030 dout = ram_o combinationally; dout is don't-care while dv=0.
REQ-031 ovf sets on wr & full & ~clr; unf sets on rd & empty & ~clr; both clear only on rst or clr.
REQ-032 clr: wptr, rptr and count go to 0; ovf, unf and dv go to 0; clr has priority over wr and rd in the same cycle.
REQ-033 Read-during-write to the same address cannot occur, because pops are gated by empty and count is registered.

Reset
REQ-034 On rst assertion, immediately and asynchronously: wptr = rptr = 0, count = 0, dv = 0, ovf = unf = 0.
REQ-035 Status while rst is held: empty = 1, full = 0, almost_empty = 1, almost_full = 0; ram_wce, ram_we and ram_rce are 0.
REQ-036 rst asserted mid-stream discards all queued data; the first accepted push after release goes to address 0.

Verification
REQ-037 After reset, push 0x11, 0x22, 0x33, then pop 3 times back to back -> dv high for 3 consecutive cycles with dout = 0x11, 0x22, 0x33; empty=1 and count=0 afterwards.
REQ-038 Push 4096 bytes -> full=1, count=4096; a 4097th push is dropped and sets ovf=1; pop 4096 bytes -> data in push order, empty=1.
REQ-039 Wrap-around: push/pop 5000 bytes while keeping count between 1 and 10 -> the pointers wrap 4095 -> 0 and data order is preserved.
REQ-040 With count=5, wr and rd in the same cycle -> count stays 5 and dv=1 on the next cycle; with count=0, wr and rd together -> only the push is taken, count=1, dv=0, unf=1.
REQ-041 Thresholds: filling from empty -> almost_empty drops when count goes from 256 to 257; almost_full rises when count reaches 3840.
REQ-042 Flush and reset: clr with wr=rd=1 at count=100 -> count=0, no RAM write; rst asserted mid-pop -> dv=0 and empty=1 with no clock edge.
